// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU flag types and helpers shared by the adder and the flag register
package alu_pkg;

  localparam int FLAG_W = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  // Two's-complement overflow: operands agree in sign, result disagrees.
  function automatic logic signed_overflow(input logic sign_a, input logic sign_b,
                                           input logic sign_sum);
    return (sign_a == sign_b) && (sign_sum != sign_a);
  endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// rtl/pipe_adder_slice.sv - one CW-bit chunk add plus its stage register and valid/ready handshake
module pipe_adder_slice #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic          down_ready,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          sub,
  input  logic          cin,
  output logic          valid,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          load
);

  logic [CW:0] total;

  assign up_ready = !valid || down_ready;
  assign load     = up_valid && up_ready;
  assign total    = {1'b0, a} + {1'b0, b ^ {CW{sub}}} + {{CW{1'b0}}, cin};

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (up_ready) begin
      valid <= up_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      {cout, sum} <= total;
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined WIDTH-bit add/sub, one chunk per stage with valid/ready back-pressure
// Define PIPE_ADDER_FLAGS_EN to produce NZCV flags; otherwise out_flags is tied to zero.
module pipe_adder
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_a,
  input  logic [WIDTH-1:0]  in_b,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_sum,
  output logic [FLAG_W-1:0] out_flags
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be a positive multiple of STAGES");
  end

  logic [STAGES:0]   ready;
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] carry;
  logic [STAGES-1:0] sub_pipe;
  logic [WIDTH-1:0]  a_pipe   [STAGES];
  logic [WIDTH-1:0]  b_pipe   [STAGES];
  logic [WIDTH-1:0]  sum_pipe [STAGES];
`ifdef PIPE_ADDER_FLAGS_EN
  logic [STAGES-1:0] zero_pipe;
`endif

  assign ready[STAGES] = out_ready;
  assign in_ready      = ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_src, b_src, sum_src;
    logic [WIDTH-1:0] a_q, b_q, sum_q, assembled;
    logic             up_valid, sub_src, cin_src, sub_q, load;
    logic [CW-1:0]    chunk;
`ifdef PIPE_ADDER_FLAGS_EN
    logic             zero_src, zero_q;
`endif

    if (k == 0) begin : g_head
      assign a_src    = in_a;
      assign b_src    = in_b;
      assign sum_src  = '0;
      assign up_valid = in_valid;
      assign sub_src  = in_sub;
      assign cin_src  = in_sub;
`ifdef PIPE_ADDER_FLAGS_EN
      assign zero_src = 1'b1;
`endif
    end else begin : g_tail
      assign a_src    = a_pipe[k-1];
      assign b_src    = b_pipe[k-1];
      assign sum_src  = sum_pipe[k-1];
      assign up_valid = valid[k-1];
      assign sub_src  = sub_pipe[k-1];
      assign cin_src  = carry[k-1];
`ifdef PIPE_ADDER_FLAGS_EN
      assign zero_src = zero_pipe[k-1];
`endif
    end

    pipe_adder_slice #(.CW(CW)) u_slice (
      .clk        (clk),
      .reset      (reset),
      .up_valid   (up_valid),
      .up_ready   (ready[k]),
      .down_ready (ready[k+1]),
      .a          (a_src[k*CW +: CW]),
      .b          (b_src[k*CW +: CW]),
      .sub        (sub_src),
      .cin        (cin_src),
      .valid      (valid[k]),
      .sum        (chunk),
      .cout       (carry[k]),
      .load       (load)
    );

    // Operands travel whole so the last stage still sees the sign bits.
    always_ff @(posedge clk) begin
      if (load) begin
        a_q   <= a_src;
        b_q   <= b_src;
        sum_q <= sum_src;
        sub_q <= sub_src;
`ifdef PIPE_ADDER_FLAGS_EN
        zero_q <= zero_src;
`endif
      end
    end

    always_comb begin
      assembled              = sum_q;
      assembled[k*CW +: CW]  = chunk;
    end

    assign a_pipe[k]   = a_q;
    assign b_pipe[k]   = b_q;
    assign sum_pipe[k] = assembled;
    assign sub_pipe[k] = sub_q;
`ifdef PIPE_ADDER_FLAGS_EN
    assign zero_pipe[k] = zero_q && (chunk == '0);
`endif
  end

  alu_flags_t flags;

`ifdef PIPE_ADDER_FLAGS_EN
  assign flags = '{
    n: sum_pipe[LAST][WIDTH-1],
    z: zero_pipe[LAST],
    c: carry[LAST],
    v: signed_overflow(a_pipe[LAST][WIDTH-1],
                       b_pipe[LAST][WIDTH-1] ^ sub_pipe[LAST],
                       sum_pipe[LAST][WIDTH-1])
  };
`else
  assign flags = '0;
`endif

  // Outputs read as zero whenever no result is present, including straight after reset.
  assign out_valid = valid[LAST];
  assign out_sum   = out_valid ? sum_pipe[LAST] : '0;
  assign out_flags = out_valid ? flags : '0;

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - randomized scoreboard bench for pipe_adder against an arithmetic reference
module tb_pipe_adder;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [3:0]       out_flags;

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic [3:0]       flags;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   lat_chk  = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [3:0] cfg_flags(input logic [3:0] f);
`ifdef PIPE_ADDER_FLAGS_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  // Reference: plain integer add/sub; borrow and signed overflow from wide arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic sub);
    exp_t               e;
    logic [WIDTH:0]     wide;
    logic signed [65:0] sw;
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    sa = $signed({{2{a[WIDTH-1]}}, a});
    sb = $signed({{2{b[WIDTH-1]}}, b});
    if (sub) begin
      wide[WIDTH-1:0] = a - b;
      wide[WIDTH]     = (a >= b);
      sw              = sa - sb;
    end else begin
      wide = {1'b0, a} + {1'b0, b};
      sw   = sa + sb;
    end
    e.sum   = wide[WIDTH-1:0];
    e.flags = cfg_flags({wide[WIDTH-1], wide[WIDTH-1:0] == '0, wide[WIDTH], sw[64] != sw[63]});
    e.cyc   = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("sb_sum", out_sum, e.sum);
          check("sb_flags", out_flags, e.flags);
          if (lat_chk) check("sb_latency", cyc - e.cyc, STAGES);
        end
      end
      if (in_valid && in_ready) begin
        e     = model(in_a, in_b, in_sub);
        e.cyc = cyc;
        exp_q.push_back(e);
      end
    end
  end

  task automatic drive_random();
    in_valid = 1'b1;
    case ($urandom_range(0, 3))
      0:       in_a = '1;
      1:       in_a = '0;
      default: in_a = {$urandom, $urandom};
    endcase
    in_b   = ($urandom_range(0, 3) == 0) ? '1 : {$urandom, $urandom};
    in_sub = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clk);
    #1;
    check(tag, exp_q.size(), 0);
  endtask

  task automatic directed(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic [WIDTH-1:0] want_sum,
                          input logic [3:0] want_flags);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = {$urandom, $urandom};
    n        = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, STAGES);
    check({tag, "_sum"}, out_sum, want_sum);
    check({tag, "_flags"}, out_flags, cfg_flags(want_flags));
    @(posedge clk);
    #1;
  endtask

  int               accepts;
  int               stale;
  bit               held_valid;
  logic [WIDTH-1:0] held_sum;
  logic [3:0]       held_flags;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    directed("carry_chain", 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 4'b0000);
    directed("sub_equal", 64'd5, 64'd5, 1'b1, 64'h0, 4'b0110);
    directed("sub_borrow", 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    directed("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001);
    directed("add_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFE, 4'b1010);
    directed("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0101);

    // Back-to-back stream: one accept and, once full, one result every cycle.
    for (int i = 0; i < 100; i++) begin
      drive_random();
      @(posedge clk);
      #1;
      check("stream_in_ready", in_ready, 1'b1);
      if (i >= STAGES - 1) check("stream_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    drain("stream_drained");

    lat_chk    = 1'b0;
    out_ready  = 1'b0;
    accepts    = 0;
    held_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_random();
      #1;
      if (in_ready) accepts++;
      if (out_valid) begin
        if (!held_valid) begin
          held_sum   = out_sum;
          held_flags = out_flags;
          held_valid = 1'b1;
        end else begin
          check("stall_sum_stable", out_sum, held_sum);
          check("stall_flags_stable", out_flags, held_flags);
        end
      end
      @(posedge clk);
      #1;
    end
    check("stall_accepts", accepts, STAGES);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("stall_drained");
    lat_chk = 1'b1;

    for (int i = 0; i < 3; i++) begin
      drive_random();
      @(posedge clk);
      #1;
    end
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_sum", out_sum, 0);
    check("midrst_out_flags", out_flags, 0);
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("midrst_no_stale", stale, 0);
    check("midrst_in_ready", in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
